// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port synchronous SRAM between the
// instruction-fetch (i_*) and data-access (d_*) requesters. At most one access
// is issued per cycle. A tag pipeline of SRAM_LAT stages carries each access
// so that its response goes back only to the requester that issued it.
// Build option: define ARB_RR_EN for round-robin arbitration on contention.
// By default, data has priority and a starvation guard forces inst after
// STARVE_MAX consecutive denials.
module sram_port_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned SRAM_LAT   = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            i_req,
    input  logic            i_wr,
    input  logic [DW/8-1:0] i_wstrb,
    input  logic [AW-1:0]   i_addr,
    input  logic [DW-1:0]   i_wdata,
    output logic            i_addr_ok,
    output logic            i_data_ok,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_wr,
    input  logic [DW/8-1:0] d_wstrb,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_addr_ok,
    output logic            d_data_ok,
    output logic [DW-1:0]   d_rdata,
    output logic            sram_en,
    output logic [DW/8-1:0] sram_we,
    output logic [AW-1:0]   sram_addr,
    output logic [DW-1:0]   sram_wdata,
    input  logic [DW-1:0]   sram_rdata
);

    localparam int unsigned SW  = DW / 8;
    localparam int unsigned LAT = SRAM_LAT;

    logic gnt_i;
    logic gnt_d;

`ifdef ARB_RR_EN
    // last_gnt: 1 = data was granted last, 0 = inst was granted last
    logic last_gnt_q;
    logic last_gnt_d;

    // Round-robin grant on contention; a lone requester always wins
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (i_req && d_req) begin
            gnt_d = ~last_gnt_q;
            gnt_i = last_gnt_q;
        end else begin
            gnt_d = d_req;
            gnt_i = i_req;
        end
        if (!resetn) begin
            gnt_i = 1'b0;
            gnt_d = 1'b0;
        end
    end

    // Remember the winner of every grant
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt_i || gnt_d) begin
            last_gnt_d = gnt_d;
        end
    end

    // Last-grant register; reset points at data so inst wins first contention
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`else
    localparam int unsigned CW       = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam bit          GUARD_EN = (STARVE_MAX != 0);

    logic [CW-1:0] starve_cnt_q;
    logic [CW-1:0] starve_cnt_d;
    logic          force_i;

    // Fixed data priority unless inst has been denied STARVE_MAX times in a row
    always_comb begin
        force_i = GUARD_EN && (starve_cnt_q == CW'(STARVE_MAX));
        gnt_d   = d_req & ~force_i;
        gnt_i   = i_req & ~gnt_d;
        if (!resetn) begin
            gnt_i = 1'b0;
            gnt_d = 1'b0;
        end
    end

    // Saturating count of consecutive inst denials
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!i_req || gnt_i) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != CW'(STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    // SRAM request mux driven from the granted requester
    always_comb begin
        sram_en    = gnt_i | gnt_d;
        sram_addr  = gnt_i ? i_addr  : d_addr;
        sram_wdata = gnt_i ? i_wdata : d_wdata;
        sram_we    = '0;
        if (gnt_i && i_wr) begin
            sram_we = i_wstrb;
        end else if (gnt_d && d_wr) begin
            sram_we = d_wstrb;
        end
    end

    assign i_addr_ok = gnt_i;
    assign d_addr_ok = gnt_d;

    logic [LAT-1:0] vld_q;
    logic [LAT-1:0] vld_d;
    logic [LAT-1:0] own_q;
    logic [LAT-1:0] own_d;

    // Tag pipe shift: stage 0 takes this cycle's issue, owner 1 = data
    always_comb begin
        vld_d    = '0;
        own_d    = '0;
        vld_d[0] = sram_en;
        own_d[0] = gnt_d;
        for (int unsigned k = 1; k < LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            own_d[k] = own_q[k-1];
        end
    end

    // Tag pipe registers; reset drops every in-flight access
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_q <= '0;
            own_q <= '0;
        end else begin
            vld_q <= vld_d;
            own_q <= own_d;
        end
    end

    assign i_data_ok = vld_q[LAT-1] & ~own_q[LAT-1];
    assign d_data_ok = vld_q[LAT-1] &  own_q[LAT-1];
    assign i_rdata   = sram_rdata;
    assign d_rdata   = sram_rdata;

    // Strobe width must cover whole bytes of the data bus
    if (SW * 8 != DW) begin : g_bad_dw
        $error("DW must be a multiple of 8");
    end
    if (LAT < 1 || LAT > 4) begin : g_bad_lat
        $error("SRAM_LAT must be in 1..4");
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized bench for sram_port_arbiter with a behavioural SRAM and a
// transaction-level reference model of grants and response ordering.
module tb_sram_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SW   = DW / 8;
    localparam int unsigned LAT  = 1;
    localparam int unsigned SMAX = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          i_req = 1'b0, d_req = 1'b0;
    logic          i_wr = 1'b0, d_wr = 1'b0;
    logic [SW-1:0] i_wstrb = '0, d_wstrb = '0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] i_wdata = '0, d_wdata = '0;
    logic          i_addr_ok, d_addr_ok, i_data_ok, d_data_ok;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          sram_en;
    logic [SW-1:0] sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;

    sram_port_arbiter #(.AW(AW), .DW(DW), .SRAM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_wr(i_wr), .i_wstrb(i_wstrb), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: word array indexed by addr[9:2], read data after LAT edges
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rd_pipe [LAT];

    always @(posedge clk) begin
        if (sram_en) begin
            rd_pipe[0] <= mem[sram_addr[9:2]];
            for (int unsigned b = 0; b < SW; b++) begin
                if (sram_we[b]) mem[sram_addr[9:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end
        end else begin
            rd_pipe[0] <= 32'hDEAD_BEEF;
        end
        for (int unsigned k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign sram_rdata = rd_pipe[LAT-1];

    typedef struct packed {
        logic          vld;
        logic          own_d;
        logic          is_rd;
        logic [DW-1:0] data;
    } resp_t;

    resp_t       rq[$];
    int unsigned starve = 0;
    bit          last_d = 1'b1;
    bit          acc_i = 1'b0, acc_d = 1'b0;
    bit          seen_i = 1'b0;
    int          pass_cnt = 0;
    int          chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        else pass_cnt++;
    endtask

    task automatic rand_i();
        i_req   = 1'b1;
        i_wr    = 1'($urandom_range(0, 1));
        i_wstrb = SW'($urandom);
        i_addr  = $urandom & 32'hFFFF_FFFC;
        i_wdata = $urandom;
    endtask

    task automatic rand_d();
        d_req   = 1'b1;
        d_wr    = 1'($urandom_range(0, 1));
        d_wstrb = SW'($urandom);
        d_addr  = $urandom & 32'hFFFF_FFFC;
        d_wdata = $urandom;
    endtask

    task automatic check_rst_zero(input string tag);
        check({tag, "_i_addr_ok"}, 32'(i_addr_ok), 0);
        check({tag, "_d_addr_ok"}, 32'(d_addr_ok), 0);
        check({tag, "_i_data_ok"}, 32'(i_data_ok), 0);
        check({tag, "_d_data_ok"}, 32'(d_data_ok), 0);
        check({tag, "_sram_en"},   32'(sram_en), 0);
        check({tag, "_sram_we"},   32'(sram_we), 0);
    endtask

    task automatic clear_model();
        rq.delete();
        starve = 0;
        last_d = 1'b1;
        acc_i  = 1'b0;
        acc_d  = 1'b0;
    endtask

    // One cycle: responses, stimulus (mode 0 random, 1 both held, 2 caller-driven),
    // grant checks, then either a clock edge or a reset pulse that kills in-flight work
    task automatic step(input int mode, input bit rst_mid);
        resp_t e;
        logic  eg_i, eg_d, wr;
        logic [SW-1:0] strb;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        e = '0;
        if (rq.size() >= LAT) e = rq.pop_front();
        check("i_data_ok", 32'(i_data_ok), 32'(e.vld & ~e.own_d));
        check("d_data_ok", 32'(d_data_ok), 32'(e.vld & e.own_d));
        if (e.vld && e.is_rd) begin
            if (e.own_d) check("d_rdata", d_rdata, e.data);
            else         check("i_rdata", i_rdata, e.data);
        end

        if (mode == 0) begin
            if (acc_i) i_req = 1'b0;
            else if (i_req && $urandom_range(0, 15) == 0) i_req = 1'b0;
            else if (!i_req && $urandom_range(0, 1) == 1) rand_i();
            if (acc_d) d_req = 1'b0;
            else if (d_req && $urandom_range(0, 15) == 0) d_req = 1'b0;
            else if (!d_req && $urandom_range(0, 1) == 1) rand_d();
        end else if (mode == 1) begin
            if (acc_i || !i_req) rand_i();
            if (acc_d || !d_req) rand_d();
        end
        #1;

`ifdef ARB_RR_EN
        if (i_req && d_req) eg_d = !last_d;
        else                eg_d = d_req;
        eg_i = i_req && !eg_d;
        if (eg_i || eg_d) last_d = eg_d;
`else
        eg_d = d_req && !(SMAX > 0 && starve >= SMAX);
        eg_i = i_req && !eg_d;
        if (!i_req || eg_i) starve = 0;
        else if (starve < SMAX) starve = starve + 1;
`endif
        check("i_addr_ok", 32'(i_addr_ok), 32'(eg_i));
        check("d_addr_ok", 32'(d_addr_ok), 32'(eg_d));
        check("sram_en",   32'(sram_en),   32'(eg_i | eg_d));
        wr = eg_i ? i_wr : d_wr;
        strb = eg_i ? i_wstrb : d_wstrb;
        a = eg_i ? i_addr : d_addr;
        wd = eg_i ? i_wdata : d_wdata;
        if (eg_i || eg_d) begin
            check("sram_addr",  sram_addr, a);
            check("sram_wdata", sram_wdata, wd);
            check("sram_we",    32'(sram_we), wr ? 32'(strb) : 0);
        end
        acc_i  = eg_i;
        acc_d  = eg_d;
        seen_i = i_addr_ok;
        rq.push_back('{vld: eg_i | eg_d, own_d: eg_d, is_rd: !wr, data: mem[a[9:2]]});

        if (rst_mid) begin
            resetn = 1'b0;
            i_req  = 1'b0;
            d_req  = 1'b0;
            #1;
            check_rst_zero("mid_rst");
            clear_model();
            @(posedge clk); #1;
            check_rst_zero("mid_rst_edge");
            @(negedge clk);
            resetn = 1'b1;
            @(posedge clk); #1;
        end else begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= $urandom;
        for (int k = 0; k < int'(LAT); k++) rd_pipe[k] <= '0;

        // Reset held with both requests asserted: nothing may leak out
        resetn = 1'b0;
        rand_i();
        rand_d();
        #1;
        check_rst_zero("rst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_rst_zero("rst_edge");
        clear_model();
        resetn = 1'b1;
        step(2, 1'b0);
        check("rel_d_first", 32'(d_addr_ok), 1);
        i_req = 1'b0;
        d_req = 1'b0;
        step(2, 1'b0);
        step(2, 1'b0);

        // Lone inst read at 0x1c000000 and a lone data write with partial strobe
        i_req = 1'b1; i_wr = 1'b0; i_addr = 32'h1c00_0000; i_wdata = $urandom;
        step(2, 1'b0);
        i_req = 1'b0;
        step(2, 1'b0);
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'h1234_5678; d_wstrb = 4'b0011;
        step(2, 1'b0);
        d_req = 1'b0;
        step(2, 1'b0);
        // Read back the written word: low half updated, high half unchanged
        d_req = 1'b1; d_wr = 1'b0;
        step(2, 1'b0);
        d_req = 1'b0;
        step(2, 1'b0);

`ifndef ARB_RR_EN
        // Continuous contention: d,d,d,d,i repeating
        for (int k = 0; k < 15; k++) begin
            step(1, 1'b0);
            check("contend_pat_i", 32'(seen_i), 32'(k % 5 == 4));
        end
`else
        // Round-robin after reset: i,d,i,d,...
        i_req = 1'b0;
        d_req = 1'b0;
        step(2, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(1, 1'b0);
            check("rr_pat_i", 32'(seen_i), 32'(k % 2 == 0));
        end
`endif

        // Long random run with occasional reset pulses over in-flight accesses
        for (int n = 0; n < 3000; n++) begin
            step(0, $urandom_range(0, 199) == 0);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        for (int n = 0; n < int'(LAT) + 1; n++) step(2, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
